rr_req_arbiter: RTL and testbench
=================================

Name: rr_req_arbiter

Overview:
- Round-robin arbiter that shares one resource among N_REQ requesters using a registered, one-hot grant.
- Each grant is held while the owner keeps its request high, up to MAX_HOLD cycles. After that the owner is preempted if anyone else is waiting.
- Sits between requester agents and the shared resource. Its req/gnt signals are the targets of the team's concurrent-assertion checkers.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum consecutive grant cycles before forced handoff (>=2).
- CNT_W, $clog2(MAX_HOLD+1), hold-counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester request level.
- gnt  output  N_REQ  one-hot grant, registered; all-zero when idle.
- busy  output  1  high when any grant is active (equals |gnt).
- owner  output  $clog2(N_REQ)  index of the current grantee; holds the last owner when idle.
- hold_cnt  output  CNT_W  cycles elapsed in the current grant (1 on the first grant cycle).
- preempt  output  1  one-cycle pulse on the edge where a timeout forces handoff.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - gnt=0, busy=0, owner=N_REQ-1 (so requester 0 has first priority), hold_cnt=0, preempt=0, state=IDLE.
- States: IDLE, OWNED.
- Latency: req sampled at edge k produces gnt at edge k+1. There is no combinational path from req to gnt.
- IDLE:
  - If req != 0: grant the first set bit searching upward, with wrap, from owner+1.
  - Then state=OWNED, hold_cnt=1.
- OWNED, owner request still high, hold_cnt < MAX_HOLD: keep the grant; hold_cnt += 1.
- OWNED, owner request dropped:
  - If another requester is pending, grant the next one by round-robin from owner+1, excluding the old owner. This is a same-edge handoff with no idle cycle; hold_cnt=1.
  - If nothing else is pending: gnt=0, state=IDLE, hold_cnt=0.
- OWNED, hold_cnt == MAX_HOLD, owner request still high:
  - If another requester is pending: hand off to the next round-robin requester, excluding the owner; preempt=1 for one cycle; hold_cnt=1.
  - If no other requester is pending: keep the grant, hold_cnt=1 (counter restarts), no preempt.
- Round-robin search: starts at owner+1 modulo N_REQ and wraps past N_REQ-1 to 0.
- Simultaneous owner drop and timeout: treated as a drop, so no preempt pulse.
- Invariants (assertion targets):
  - gnt is always one-hot or zero.
  - gnt[i] never rises without req[i] high at the preceding edge.
  - hold_cnt never exceeds MAX_HOLD.
  - With fair requesters, every continuously asserted req is granted within (N_REQ-1)*MAX_HOLD+1 cycles.
- Reset mid-grant: outputs go to reset values immediately, without waiting for a clock. Priority restarts at requester 0.

Decomposition:
- Package arb_pkg:
  - arb_state_e enum {IDLE, OWNED}.
  - function rr_next(req, start) returning the index and a found flag.
  - localparam defaults for N_REQ and MAX_HOLD.
- One natural sub-module: rr_pick, a combinational masked-priority finder (rotate, find-first, rotate back). It is reused by other arbiters in the design.
- Top level holds the FSM, hold counter and output registers.

Test Plan:
- Reset then req=4'b0101 → gnt=4'b0001 one edge later, owner=0, hold_cnt=1.
- req[0] drops while req[2]=1 → gnt=4'b0100 at the next edge with no zero-gnt cycle, hold_cnt=1, preempt=0.
- req=4'b0011 held constant, MAX_HOLD=8 → gnt alternates 0001/0010 every 8 cycles, preempt pulses once per handoff, hold_cnt never reads 9.
- req=4'b1000 alone held for 20 cycles → gnt stays 4'b1000, hold_cnt wraps 8→1, preempt stays 0.
- All req drop together → gnt=0 and busy=0 next edge. A later req=4'b1111 grants requester 0 if owner was 3 (wrap check).
- rst asserted mid-grant between clock edges → gnt=0 immediately. After release, req=4'b1110 grants requester 1.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the request arbiters: FSM state encoding,
// default sizing and a reference round-robin search.
package arb_pkg;

    localparam int ARB_N_REQ    = 4;
    localparam int ARB_MAX_HOLD = 8;

    // Widest arbiter supported by the helper function below
    localparam int MAX_REQ   = 16;
    localparam int REQ_IDX_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                 found;
        logic [REQ_IDX_W-1:0] idx;
    } rr_result_t;

    // First set bit of req at or after start (mod n), searching upward with wrap.
    function automatic rr_result_t rr_next(input logic [MAX_REQ-1:0]   req,
                                           input logic [REQ_IDX_W-1:0] start,
                                           input int                   n);
        rr_result_t r;
        int         k;
        r = '0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            k = (int'(start) + i) % n;
            if ((i < n) && req[k[REQ_IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = k[REQ_IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational masked-priority finder: rotate the request vector so that
// start_i sits at bit 0, find the first set bit, then rotate the index back.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    logic [N-1:0] rot;
    logic [IW-1:0] first;
    logic [IW:0]   sum;

    always_comb begin
        rot     = N'({req_i, req_i} >> start_i);
        found_o = |rot;
        first   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) first = IW'(i);
        end
        sum = {1'b0, start_i} + {1'b0, first};
        if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
        idx_o = sum[IW-1:0];
    end

endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter with a registered one-hot grant and a bounded hold time;
// a holder that exceeds MAX_HOLD cycles is preempted when someone else waits.
module rr_req_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = ARB_N_REQ,
    parameter int MAX_HOLD = ARB_MAX_HOLD,
    localparam int CNT_W   = $clog2(MAX_HOLD + 1),
    localparam int IDX_W   = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic [IDX_W-1:0] owner,
    output logic [CNT_W-1:0] hold_cnt,
    output logic             preempt
);

    arb_state_e       state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [IDX_W-1:0] owner_q;
    logic [CNT_W-1:0] hold_q;
    logic             preempt_q;

    logic [N_REQ-1:0] cand_d;
    logic [IDX_W-1:0] start_d;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;

    // Masking with the current grant excludes the owner from handoff searches;
    // in IDLE the grant is zero, so the old owner is simply reached last.
    always_comb begin
        cand_d  = req & ~gnt_q;
        start_d = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    end

    rr_pick #(
        .N  (N_REQ),
        .IW (IDX_W)
    ) u_pick (
        .req_i   (cand_d),
        .start_i (start_d),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            owner_q   <= IDX_W'(N_REQ - 1);
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        gnt_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        owner_q <= pick_idx;
                        hold_q  <= CNT_W'(1);
                        state_q <= OWNED;
                    end
                end
                OWNED: begin
                    // A drop takes precedence over a coincident timeout.
                    if (!req[owner_q]) begin
                        if (pick_found) begin
                            gnt_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                            owner_q <= pick_idx;
                            hold_q  <= CNT_W'(1);
                        end else begin
                            gnt_q   <= '0;
                            hold_q  <= '0;
                            state_q <= IDLE;
                        end
                    end else if (hold_q == CNT_W'(MAX_HOLD)) begin
                        hold_q <= CNT_W'(1);
                        if (pick_found) begin
                            gnt_q     <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                            owner_q   <= pick_idx;
                            preempt_q <= 1'b1;
                        end
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign busy     = |gnt_q;
    assign owner    = owner_q;
    assign hold_cnt = hold_q;
    assign preempt  = preempt_q;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Directed self-checking bench for rr_req_arbiter with the default
// N_REQ=4 / MAX_HOLD=8 configuration and hand-computed expectations.
module tb_rr_req_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] owner;
    logic [3:0] hold_cnt;
    logic       preempt;

    int checks;
    int failures;

    rr_req_arbiter #(
        .N_REQ    (4),
        .MAX_HOLD (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .busy     (busy),
        .owner    (owner),
        .hold_cnt (hold_cnt),
        .preempt  (preempt)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic [3:0] r);
        req = r;
    endtask

    // Advance one rising edge and settle 1 time unit past it
    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_gnt"},     32'(gnt),      32'h0);
        checkOutput({tag, "_busy"},    32'(busy),     32'h0);
        checkOutput({tag, "_owner"},   32'(owner),    32'h3);
        checkOutput({tag, "_hold"},    32'(hold_cnt), 32'h0);
        checkOutput({tag, "_preempt"}, 32'(preempt),  32'h0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 4'b0000;

        repeat (2) @(posedge clk);
        #1;
        checkReset("reset");
        @(negedge clk);
        rst = 1'b0;

        // First grant goes to requester 0
        applyStimulus(4'b0101);
        stepClk();
        checkOutput("first_gnt",   32'(gnt),      32'h1);
        checkOutput("first_owner", 32'(owner),    32'h0);
        checkOutput("first_hold",  32'(hold_cnt), 32'h1);
        checkOutput("first_busy",  32'(busy),     32'h1);

        // Owner drops, same-edge handoff to requester 2
        applyStimulus(4'b0100);
        stepClk();
        checkOutput("drop_gnt",     32'(gnt),      32'h4);
        checkOutput("drop_owner",   32'(owner),    32'h2);
        checkOutput("drop_hold",    32'(hold_cnt), 32'h1);
        checkOutput("drop_preempt", 32'(preempt),  32'h0);

        // Two competing requesters: search from 3 wraps to 0
        applyStimulus(4'b0011);
        stepClk();
        checkOutput("rr_gnt0",  32'(gnt),      32'h1);
        checkOutput("rr_hold0", 32'(hold_cnt), 32'h1);
        for (int i = 0; i < 7; i++) begin
            stepClk();
            checkOutput("rr_count_a", 32'(hold_cnt), 32'(i + 2));
            checkOutput("rr_nopre_a", 32'(preempt),  32'h0);
        end
        stepClk();
        checkOutput("to_gnt1",     32'(gnt),      32'h2);
        checkOutput("to_preempt1", 32'(preempt),  32'h1);
        checkOutput("to_hold1",    32'(hold_cnt), 32'h1);
        checkOutput("to_owner1",   32'(owner),    32'h1);
        stepClk();
        checkOutput("to_pulse_end", 32'(preempt),  32'h0);
        checkOutput("to_hold2",     32'(hold_cnt), 32'h2);
        checkOutput("to_keep",      32'(gnt),      32'h2);
        repeat (6) stepClk();
        checkOutput("rr_hold_max", 32'(hold_cnt), 32'h8);
        stepClk();
        checkOutput("to_back_gnt",     32'(gnt),     32'h1);
        checkOutput("to_back_preempt", 32'(preempt), 32'h1);

        // Lone requester 3: counter restarts, never preempted
        applyStimulus(4'b1000);
        stepClk();
        checkOutput("lone_gnt",  32'(gnt),      32'h8);
        checkOutput("lone_hold", 32'(hold_cnt), 32'h1);
        checkOutput("lone_pre",  32'(preempt),  32'h0);
        for (int i = 0; i < 19; i++) begin
            stepClk();
            checkOutput("lone_keep",    32'(gnt),      32'h8);
            checkOutput("lone_nopre",   32'(preempt),  32'h0);
            checkOutput("lone_counter", 32'(hold_cnt), 32'(((i + 1) % 8) + 1));
        end

        // Everyone drops: idle next edge, owner held
        applyStimulus(4'b0000);
        stepClk();
        checkOutput("idle_gnt",   32'(gnt),      32'h0);
        checkOutput("idle_busy",  32'(busy),     32'h0);
        checkOutput("idle_owner", 32'(owner),    32'h3);
        checkOutput("idle_hold",  32'(hold_cnt), 32'h0);

        // Owner was 3, so all-request grants wrap to requester 0
        applyStimulus(4'b1111);
        stepClk();
        checkOutput("wrap_gnt",   32'(gnt),   32'h1);
        checkOutput("wrap_owner", 32'(owner), 32'h0);
        stepClk();
        checkOutput("wrap_hold", 32'(hold_cnt), 32'h2);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        checkReset("async_rst");
        applyStimulus(4'b1110);
        @(negedge clk);
        rst = 1'b0;
        stepClk();
        checkOutput("post_rst_gnt",   32'(gnt),   32'h2);
        checkOutput("post_rst_owner", 32'(owner), 32'h1);

        // Owner drop coinciding with timeout is a plain drop
        repeat (7) stepClk();
        checkOutput("coinc_hold", 32'(hold_cnt), 32'h8);
        applyStimulus(4'b0100);
        stepClk();
        checkOutput("coinc_gnt",     32'(gnt),      32'h4);
        checkOutput("coinc_preempt", 32'(preempt),  32'h0);
        checkOutput("coinc_hold1",   32'(hold_cnt), 32'h1);
        checkOutput("coinc_owner",   32'(owner),    32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
